// File: rtl/out_port_ctrl.sv
// Output-port controller for OUT: buffers BusMuxOut words in a small FIFO and
// presents them through a registered valid/ready port. Optional OUT_PORT_PARITY_EN adds OutParity.
module out_port_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    OutPortin,
  input  logic [DATA_WIDTH-1:0]   BusMuxOut,
  output logic                    Stall,
  output logic                    Overflow,
  input  logic                    OverflowClr,
  output logic [DATA_WIDTH-1:0]   OutPortData,
  output logic                    OutValid,
  input  logic                    OutReady,
`ifdef OUT_PORT_PARITY_EN
  output logic                    OutParity,
`endif
  output logic [$clog2(DEPTH):0]  Count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [0:0]            state_q, state_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic out_free;
  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic push;
  logic drop;

  assign fifo_full  = (count_q == FULL_C);
  assign fifo_empty = (count_q == '0);

  // The output register can take a new word when it is empty or being handed off this edge.
  assign out_free = (state_q == ST_IDLE) || OutReady;
  assign pop      = !fifo_empty && out_free;
  assign push     = OutPortin && (!fifo_full || pop);
  assign drop     = OutPortin && fifo_full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    state_d    = state_q;
    overflow_d = overflow_q;
    out_data_d = out_data_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PW'(1);
      out_data_d = mem_q[rd_ptr_q];
    end

    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (OutReady && !pop) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A drop on the same edge as a clear request leaves the flag set.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (OverflowClr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      overflow_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
      out_data_q <= out_data_d;
    end
  end

  // Storage array has no reset so it maps onto RAM; contents are only read after a write.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= BusMuxOut;
    end
  end

`ifdef OUT_PORT_PARITY_EN
  logic out_parity_q, out_parity_d;

  always_comb begin
    out_parity_d = out_parity_q;
    if (pop) begin
      out_parity_d = ^mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      out_parity_q <= 1'b0;
    end else begin
      out_parity_q <= out_parity_d;
    end
  end

  assign OutParity = out_parity_q;
`endif

  assign Stall       = fifo_full;
  assign Overflow    = overflow_q;
  assign OutPortData = out_data_q;
  assign OutValid    = (state_q == ST_SEND);
  assign Count       = count_q;

endmodule
